ternary_mvm_stream: RTL and testbench
=====================================

Name: ternary_mvm_stream

Overview:
- Parametrised successor to the fixed 16x8 ternary matrix-vector multiplier.
- Streams an InLen-element signed vector in Lanes elements per beat and multiplies it by a ternary InLen x OutLen weight matrix.
- Drains the OutLen results one per beat on a valid/ready output stream.
- Accumulation of the next vector overlaps draining of the previous one. Sits between the activation input shifter and the output serialiser of the ternary inference datapath.

Parameters:
- InLen, 16, number of input vector elements; must be a multiple of Lanes.
- OutLen, 8, number of output elements (matrix columns); at least 2.
- BitWidth, 8, signed width of input and output elements.
- Lanes, 2, input elements accepted per beat; must be at least 1.
- AccWidth (localparam), BitWidth+$clog2(InLen)+1, signed accumulator width; no accumulator overflow is possible.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  vec_in beat is valid.
- in_ready  output  1  block accepts a beat this cycle.
- vec_in  input  BitWidth*Lanes  lane l = vec_in[l*BitWidth +: BitWidth], signed.
- w  input  2*InLen*OutLen  weight for input i, output j = w[2*(i*OutLen+j) +: 2].
- out_valid  output  1  vec_out holds a valid result.
- out_ready  input  1  consumer accepts vec_out this cycle.
- vec_out  output  BitWidth  signed result element.
- out_last  output  1  high with element OutLen-1.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, vec_out=0, out_last=0, beat counter=0, drain index=0, all accumulators=0, drain buffer empty, pending flag clear. in_ready=1 once rst deasserts.
- Weight decode: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
- w is sampled at every accepted beat. The producer holds w stable for all beats of one vector.
- Input accept: a beat is accepted when in_valid && in_ready.
- Beat k carries elements k*Lanes .. k*Lanes+Lanes-1.
- On beat 0, each acc[j] is loaded with the beat's partial sum; on later beats the partial sum is added to acc[j]. Arithmetic is sign-extended to AccWidth.
- Vector completion: the beat with k = InLen/Lanes-1 completes the vector.
  - If the drain buffer is empty, or its last element handshakes in the same cycle: the OutLen accumulators are copied into the drain buffer at that edge, the beat counter returns to 0, and in_ready stays 1.
  - Otherwise the pending flag is set and in_ready=0. The copy happens on the edge where the drain buffer frees; the pending flag clears and in_ready returns to 1 the cycle after.
- Latency: the first result is on vec_out with out_valid=1 one cycle after the completing beat is accepted (unstalled case).
- Drain FSM, states EMPTY and DRAIN:
  - EMPTY -> DRAIN on a buffer load.
  - In DRAIN, vec_out = narrow(buf[idx]) and out_valid=1.
  - On out_valid && out_ready, idx increments.
  - On the handshake with idx=OutLen-1 (out_last=1), idx returns to 0. The FSM goes to EMPTY, or stays in DRAIN with fresh data if a load coincides.
  - vec_out and out_last are held stable while out_valid && !out_ready.
- Narrowing (default): wrap, i.e. keep the low BitWidth bits of the accumulator.
- in_valid=0 mid-vector: partial accumulation is held indefinitely; there is no timeout.
- Reset mid-operation discards any partial vector, any pending vector and any undrained results.

Optional Feature:
- Macro: TERNARY_MVM_SATURATE_EN.
- Defined: narrowing clamps the accumulator to [-2^(BitWidth-1), 2^(BitWidth-1)-1].
- Undefined: wrap narrowing as above.
- Timing and handshakes are identical in both builds.

Test Plan:
- Defaults, all w=01, 8 beats of vec_in lanes=1 -> 8 outputs each 16 (0x10) on consecutive cycles with out_ready=1; out_last only on the 8th; first out_valid 1 cycle after beat 7.
- Column 0 weights all 11, other columns 00, inputs all 3 -> out0=-48 (0xD0), out1..7=0. Repeat with all weights 10 -> all 0.
- All w=01, inputs 100 -> sum 1600. Default build: every output 0x40. With TERNARY_MVM_SATURATE_EN: every output 0x7F. Inputs -100 saturate to 0x80.
- Backpressure: out_ready low for 12 cycles from element 2 while a second vector streams in.
  - vec_out holds element 2 throughout.
  - in_ready drops the cycle after the second vector's 8th beat.
  - Draining resumes in order; second vector results follow the first's out_last with no gap or loss.
- rst pulsed after 3 accepted beats -> out_valid=0 immediately. The next full vector (inputs 1, w=01) yields 16s, not 16 plus stale partials.
- Lanes=4, InLen=8, OutLen=4 build; inputs 1..8, weights alternating +1/-1 by input index, same for every column -> each output -4 (0xFC) after 2 beats.

Source files
------------

// File: rtl/ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiplier: Lanes inputs per beat, OutLen results drained one per beat.
// Define TERNARY_MVM_SATURATE_EN to clamp results to the signed BitWidth range instead of wrapping.
module ternary_mvm_stream #(
    parameter int InLen    = 16,
    parameter int OutLen   = 8,
    parameter int BitWidth = 8,
    parameter int Lanes    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BitWidth*Lanes-1:0]   vec_in,
    input  logic [2*InLen*OutLen-1:0]   w,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BitWidth-1:0]         vec_out,
    output logic                        out_last
);

    localparam int AccWidth = BitWidth + $clog2(InLen) + 1;
    localparam int Beats    = InLen / Lanes;
    localparam int CntW     = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int IdxW     = $clog2(OutLen);

`ifdef TERNARY_MVM_SATURATE_EN
    localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((2 ** (BitWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] SatMin = -SatMax - AccWidth'(1);
`endif

    typedef enum logic {
        EMPTY,
        DRAIN
    } drain_state_t;

    drain_state_t state, state_next;

    logic [CntW-1:0]            beat_cnt;
    logic [IdxW-1:0]            idx;
    logic                       pending;
    logic signed [AccWidth-1:0] acc       [OutLen];
    logic signed [AccWidth-1:0] acc_next  [OutLen];
    logic signed [AccWidth-1:0] psum      [OutLen];
    logic signed [AccWidth-1:0] drain_buf [OutLen];
    logic signed [AccWidth-1:0] lane_ext  [Lanes];

    logic accept;
    logic last_beat;
    logic out_fire;
    logic buf_free;
    logic load;

    function automatic logic [BitWidth-1:0] narrow(input logic signed [AccWidth-1:0] a);
`ifdef TERNARY_MVM_SATURATE_EN
        if (a > SatMax) return SatMax[BitWidth-1:0];
        if (a < SatMin) return SatMin[BitWidth-1:0];
`endif
        return a[BitWidth-1:0];
    endfunction

    assign in_ready  = !pending;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == CntW'(Beats - 1));
    assign out_fire  = out_valid && out_ready;
    // The buffer can take a new vector when idle or when its final element leaves this cycle.
    assign buf_free  = (state == EMPTY) || (out_fire && out_last);
    assign load      = buf_free && (pending || (accept && last_beat));

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        assign lane_ext[l] = {{(AccWidth - BitWidth){vec_in[(l + 1) * BitWidth - 1]}},
                              vec_in[l * BitWidth +: BitWidth]};
    end

    always_comb begin : partial_sums
        int         widx;
        logic [1:0] wt;
        widx = 0;
        wt   = '0;
        for (int j = 0; j < OutLen; j++) begin
            psum[j] = '0;
            for (int l = 0; l < Lanes; l++) begin
                widx = (int'(beat_cnt) * Lanes + l) * OutLen + j;
                wt   = w[2 * widx +: 2];
                if (wt == 2'b01)
                    psum[j] = psum[j] + lane_ext[l];
                else if (wt == 2'b11)
                    psum[j] = psum[j] - lane_ext[l];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OutLen; j++) begin
            acc_next[j] = (beat_cnt == '0) ? psum[j] : acc[j] + psum[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            pending  <= 1'b0;
            for (int j = 0; j < OutLen; j++) acc[j] <= '0;
        end else begin
            if (accept) begin
                for (int j = 0; j < OutLen; j++) acc[j] <= acc_next[j];
                beat_cnt <= last_beat ? '0 : beat_cnt + CntW'(1);
            end
            // A completed vector parks in acc while pending; in_ready is low so acc cannot change.
            if (accept && last_beat && !buf_free)
                pending <= 1'b1;
            else if (pending && buf_free)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            idx   <= '0;
            for (int j = 0; j < OutLen; j++) drain_buf[j] <= '0;
        end else begin
            state <= state_next;
            if (out_fire)
                idx <= out_last ? '0 : idx + IdxW'(1);
            if (load) begin
                for (int j = 0; j < OutLen; j++)
                    drain_buf[j] <= pending ? acc[j] : acc_next[j];
            end
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        vec_out    = '0;
        case (state)
            EMPTY: begin
                if (load) state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == IdxW'(OutLen - 1));
                vec_out   = narrow(drain_buf[idx]);
                if (out_fire && out_last) state_next = load ? DRAIN : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Scoreboard bench for ternary_mvm_stream: default instance plus a Lanes=4, InLen=8, OutLen=4 instance.
// Expected results come from an integer model of the ternary products, honouring TERNARY_MVM_SATURATE_EN.
module tb_ternary_mvm_stream;

    localparam int InLen  = 16;
    localparam int OutLen = 8;

    typedef int vec_t[InLen];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  vec_in = '0;
    logic [255:0] w = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   vec_out;
    logic         out_last;

    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [31:0]  s_vec_in = '0;
    logic [63:0]  s_w = '0;
    logic         s_out_valid;
    logic         s_out_ready = 1'b1;
    logic [7:0]   s_vec_out;
    logic         s_out_last;

    logic [7:0] exp_q[$];
    int drain_pos = 0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ternary_mvm_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .w(w), .out_valid(out_valid), .out_ready(out_ready),
        .vec_out(vec_out), .out_last(out_last)
    );

    ternary_mvm_stream #(.InLen(8), .OutLen(4), .BitWidth(8), .Lanes(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .vec_in(s_vec_in), .w(s_w), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .vec_out(s_vec_out), .out_last(s_out_last)
    );

    function automatic logic [7:0] narrow8(input int s);
`ifdef TERNARY_MVM_SATURATE_EN
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return s[7:0];
    endfunction

    function automatic logic [255:0] uniform_w(input logic [1:0] c);
        logic [255:0] r;
        for (int k = 0; k < InLen * OutLen; k++) r[2*k +: 2] = c;
        return r;
    endfunction

    function automatic logic [255:0] col_w(input int col, input logic [1:0] c);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < InLen; i++) r[2*(i*OutLen+col) +: 2] = c;
        return r;
    endfunction

    function automatic logic [255:0] random_w();
        logic [255:0] r;
        for (int k = 0; k < InLen * OutLen; k++) r[2*k +: 2] = 2'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic vec_t const_vec(input int v);
        vec_t x;
        for (int i = 0; i < InLen; i++) x[i] = v;
        return x;
    endfunction

    task automatic push_expected(input vec_t x, input logic [255:0] wv);
        int s;
        for (int j = 0; j < OutLen; j++) begin
            s = 0;
            for (int i = 0; i < InLen; i++) begin
                case (wv[2*(i*OutLen+j) +: 2])
                    2'b01:   s = s + x[i];
                    2'b11:   s = s - x[i];
                    default: s = s;
                endcase
            end
            exp_q.push_back(narrow8(s));
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic feed_beat(input logic [15:0] v);
        int b;
        b = 0;
        in_valid = 1'b1;
        vec_in = v;
        while (!in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) begin
            total++;
            $display("[TB] FAIL feed_timeout: in_ready=%b expected 1 within 200 cycles", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_vec(input vec_t x, input logic [255:0] wv, input bit scored);
        logic [7:0] lo, hi;
        if (scored) push_expected(x, wv);
        w = wv;
        for (int k = 0; k < InLen / 2; k++) begin
            lo = x[2*k][7:0];
            hi = x[2*k+1][7:0];
            feed_beat({hi, lo});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_at, input int stall_len, output int cycles);
        int got;
        int stall;
        got = 0;
        stall = 0;
        cycles = 0;
        while (got < n && cycles < 400) begin
            if (got == stall_at && stall < stall_len) begin
                out_ready = 1'b0;
                stall++;
                total++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || vec_out !== exp_q[0]) begin
                    $display("[TB] FAIL stall_hold: out_valid=%b vec_out=%h expected held %h",
                             out_valid, vec_out, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
                end else passed++;
            end else begin
                out_ready = 1'b1;
                if (out_valid === 1'b1) begin
                    logic [7:0] e;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    total++;
                    if (vec_out !== e || out_last !== (drain_pos == OutLen - 1)) begin
                        $display("[TB] FAIL drain_elem%0d: vec_out=%h out_last=%b expected %h last=%b",
                                 got, vec_out, out_last, e, (drain_pos == OutLen - 1));
                    end else passed++;
                    drain_pos = (drain_pos + 1) % OutLen;
                    got++;
                end
            end
            cycles++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (got < n) begin
            total++;
            $display("[TB] FAIL drain_timeout: got %0d elements expected %0d", got, n);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || vec_out !== 8'h00 || out_last !== 1'b0) begin
            $display("[TB] FAIL reset_outputs: valid=%b vec_out=%h last=%b expected 0 00 0",
                     out_valid, vec_out, out_last);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            $display("[TB] FAIL reset_in_ready: in_ready=%b s_in_ready=%b expected 1 1", in_ready, s_in_ready);
        end else passed++;
    endtask

    task automatic test_basic();
        int cyc;
        send_vec(const_vec(1), uniform_w(2'b01), 1'b1);
        total++;
        if (out_valid !== 1'b1) begin
            $display("[TB] FAIL basic_latency: out_valid=%b expected 1", out_valid);
        end else passed++;
        drain(OutLen, -1, 0, cyc);
        total++;
        if (cyc != OutLen) begin
            $display("[TB] FAIL basic_consecutive: drain took %0d cycles expected %0d", cyc, OutLen);
        end else passed++;
        total++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL basic_idle: out_valid=%b expected 0", out_valid);
        end else passed++;
    endtask

    task automatic test_columns();
        int cyc;
        send_vec(const_vec(3), col_w(0, 2'b11), 1'b1);
        drain(OutLen, -1, 0, cyc);
        send_vec(const_vec(3), uniform_w(2'b10), 1'b1);
        drain(OutLen, -1, 0, cyc);
    endtask

    task automatic test_narrowing();
        int cyc;
        send_vec(const_vec(100), uniform_w(2'b01), 1'b1);
        drain(OutLen, -1, 0, cyc);
        send_vec(const_vec(-100), uniform_w(2'b01), 1'b1);
        drain(OutLen, -1, 0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        vec_t a, b;
        for (int i = 0; i < InLen; i++) begin
            a[i] = int'($urandom_range(0, 255)) - 128;
            b[i] = int'($urandom_range(0, 255)) - 128;
        end
        fork
            begin
                send_vec(a, random_w(), 1'b1);
                send_vec(b, random_w(), 1'b1);
            end
            drain(2 * OutLen, -1, 0, cyc);
        join
    endtask

    task automatic test_backpressure();
        int cyc;
        vec_t a, b;
        for (int i = 0; i < InLen; i++) begin
            a[i] = i + 1;
            b[i] = -2 * i - 5;
        end
        send_vec(a, random_w(), 1'b1);
        fork
            begin
                send_vec(b, random_w(), 1'b1);
                total++;
                if (in_ready !== 1'b0) begin
                    $display("[TB] FAIL bp_in_ready_drop: in_ready=%b expected 0", in_ready);
                end else passed++;
            end
            drain(2 * OutLen, 2, 12, cyc);
        join
        total++;
        if (cyc != 2 * OutLen + 12) begin
            $display("[TB] FAIL bp_no_gap: drain took %0d cycles expected %0d", cyc, 2 * OutLen + 12);
        end else passed++;
        total++;
        if (in_ready !== 1'b1) begin
            $display("[TB] FAIL bp_in_ready_back: in_ready=%b expected 1", in_ready);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b0;
        send_vec(const_vec(50), uniform_w(2'b01), 1'b1);
        w = uniform_w(2'b01);
        for (int k = 0; k < 3; k++) feed_beat({8'd7, 8'd7});
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || vec_out !== 8'h00 || out_last !== 1'b0) begin
            $display("[TB] FAIL reset_mid_outputs: valid=%b vec_out=%h last=%b expected 0 00 0",
                     out_valid, vec_out, out_last);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        drain_pos = 0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("[TB] FAIL reset_mid_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end else passed++;
        send_vec(const_vec(1), uniform_w(2'b01), 1'b1);
        drain(OutLen, -1, 0, cyc);
    endtask

    task automatic test_small_lanes();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++)
                s_w[2*(i*4+j) +: 2] = (i % 2 == 0) ? 2'b01 : 2'b11;
        s_in_valid = 1'b1;
        s_vec_in = {8'd4, 8'd3, 8'd2, 8'd1};
        @(negedge clk);
        s_vec_in = {8'd8, 8'd7, 8'd6, 8'd5};
        @(negedge clk);
        s_in_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            total++;
            if (s_out_valid !== 1'b1 || s_vec_out !== 8'hFC || s_out_last !== (e == 3)) begin
                $display("[TB] FAIL small_elem%0d: valid=%b vec_out=%h last=%b expected 1 fc %b",
                         e, s_out_valid, s_vec_out, s_out_last, (e == 3));
            end else passed++;
            @(negedge clk);
        end
        total++;
        if (s_out_valid !== 1'b0) begin
            $display("[TB] FAIL small_idle: out_valid=%b expected 0", s_out_valid);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_columns();
        test_narrowing();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_small_lanes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
